// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: iterative AES-128 decryption controller, one round per cycle; define INV_CTRL_OVERLAP_EN to accept the next block while the previous plaintext is taken
module inv_cipher_ctrl #(
  parameter int NR = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      ct_in,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      rk_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      pt_out,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} st_t;
  st_t st, st_nxt;
  logic [3:0] rnd;
  logic [127:0] state, sr, sb, ark, imc;
  logic load;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? x : 8'h00;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // inverse affine map, then multiplicative inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] isbox(input logic [7:0] b);
    logic [7:0] sq, r;
    sq = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r = gmul(r, sq);
    end
    return r;
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
      assign sb[127-8*(4*c+r) -: 8] = isbox(sr[127-8*(4*c+r) -: 8]);
      assign imc[127-8*(4*c+r) -: 8] = gmul(8'h0e, ark[127-8*(4*c+r) -: 8])
                                     ^ gmul(8'h0b, ark[127-8*(4*c+(r+1)%4) -: 8])
                                     ^ gmul(8'h0d, ark[127-8*(4*c+(r+2)%4) -: 8])
                                     ^ gmul(8'h09, ark[127-8*(4*c+(r+3)%4) -: 8]);
    end
  end

  assign ark = sb ^ rk_in;
  assign load = in_valid && in_ready;
  assign pt_out = state;

  always_ff @(posedge clk)
    if (!rst_n) st <= IDLE;
    else st <= st_nxt;

  always_ff @(posedge clk)
    if (!rst_n) begin
      rnd <= 4'(NR);
      state <= '0;
    end else if (load) begin
      state <= ct_in ^ rk_in;
      rnd <= 4'(NR - 1);
    end else if (st == ROUND) begin
      state <= imc;
      if (rnd != 4'd1) rnd <= rnd - 4'd1;
    end else if (st == FINAL) begin
      state <= ark;
    end

  always_comb begin
    st_nxt = load ? ROUND
           : st == ROUND ? (rnd == 4'd1 ? FINAL : ROUND)
           : st == FINAL ? DONE
           : (st == DONE && out_ready) ? IDLE
           : st;
  end

  always_comb begin
    busy = st == ROUND || st == FINAL;
    out_valid = st == DONE;
`ifdef INV_CTRL_OVERLAP_EN
    in_ready = st == IDLE || (st == DONE && out_ready);
    key_idx = (st == IDLE || st == DONE) ? KIDX_W'(NR) : (st == ROUND ? KIDX_W'(rnd) : '0);
`else
    in_ready = st == IDLE;
    key_idx = st == IDLE ? KIDX_W'(NR) : (st == ROUND ? KIDX_W'(rnd) : '0);
`endif
  end
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// tb_inv_cipher_ctrl: directed and random decryption checks against a forward-cipher reference model
module tb_inv_cipher_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [127:0] ct_in = '0, rk_in, pt_out;
  logic [3:0] key_idx;
  logic [127:0] rk_tab [11];
  logic [7:0] sbox [256];
  int passed = 0, failed = 0, total = 0;

  always #5 clk = ~clk;
  assign rk_in = key_idx <= 4'd10 ? rk_tab[key_idx] : '0;

  inv_cipher_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ct_in(ct_in),
    .key_idx(key_idx), .rk_in(rk_in), .out_valid(out_valid), .out_ready(out_ready),
    .pt_out(pt_out), .busy(busy)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [7:0] t [4][4];
    logic [127:0] v;
    v = p ^ rk_tab[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox[v[127-8*(4*((c+r)%4)+r) -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          v[127-8*(4*c+r) -: 8] = rd == 10 ? t[r][c]
            : gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
      v ^= rk_tab[rd];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // one block end to end with out_ready high; entered and left at a negedge in IDLE
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt, input bit seq);
    int n;
    logic [43:0] ks;
    ks = '0;
    in_valid = 1;
    ct_in = ct;
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    n = 0;
    while (!out_valid && n < 30) begin
      if (n < 11) ks = {ks[39:0], key_idx};
      @(negedge clk);
      in_valid = 0;
      n++;
    end
    chk({tag, " latency"}, 128'(n), 128'(11));
    chk({tag, " pt"}, pt_out, pt);
    if (seq) chk({tag, " key_idx seq"}, 128'(ks), 128'(44'hA9876543210));
    @(negedge clk);
    chk({tag, " back to idle"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
  endtask

  initial begin
    logic [127:0] k, p, c;
    logic [127:0] cts [2];
    logic [127:0] pts [2];
    logic [127:0] got [$];
    int acc [$];
    int n, cyc, gap;
`ifdef INV_CTRL_OVERLAP_EN
    gap = 11;
`else
    gap = 12;
`endif
    build_sbox();
    expand(128'h000102030405060708090a0b0c0d0e0f);
    repeat (2) @(negedge clk);
    chk("reset flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    chk("reset pt_out", pt_out, '0);
    chk("reset key_idx", 128'(key_idx), 128'(10));
    rst_n = 1;
    @(negedge clk);

    run_block("fips c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1);
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    run_block("fips b", 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0);

    for (int i = 0; i < 3; i++) begin
      k = rnd128();
      p = rnd128();
      expand(k);
      run_block("random", encrypt(p), p, 1);
    end

    // backpressure in DONE with ignored in_valid pulses
    p = rnd128();
    c = encrypt(p);
    in_valid = 1;
    ct_in = c;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp hold flags", 128'({out_valid, in_ready, busy}), 128'(3'b100));
      chk("bp hold pt", pt_out, p);
      in_valid = i % 2 == 1;
      ct_in = rnd128();
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    chk("bp release", 128'({out_valid, in_ready, busy}), 128'(3'b010));

    // back-to-back blocks, source and sink always ready
    expand(rnd128());
    for (int i = 0; i < 2; i++) begin pts[i] = rnd128(); cts[i] = encrypt(pts[i]); end
    cyc = 0;
    while (got.size() < 2 && cyc < 60) begin
      ct_in = cts[acc.size() > 0 ? 1 : 0];
      in_valid = acc.size() < 2;
      if (in_valid && in_ready) acc.push_back(cyc);
      if (out_valid && out_ready) got.push_back(pt_out);
      @(negedge clk);
      cyc++;
    end
    in_valid = 0;
    chk("b2b accepts", 128'(acc.size()), 128'(2));
    chk("b2b gap", 128'(acc.size() == 2 ? acc[1] - acc[0] : -1), 128'(gap));
    chk("b2b pt0", got.size() > 0 ? got[0] : 'x, pts[0]);
    chk("b2b pt1", got.size() > 1 ? got[1] : 'x, pts[1]);

    // reset in the middle of a block
    in_valid = 1;
    ct_in = rnd128();
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!(busy && key_idx == 4'd5) && n < 30) begin @(negedge clk); n++; end
    rst_n = 0;
    @(negedge clk);
    chk("midrst flags", 128'({busy, out_valid, in_ready}), 128'(3'b001));
    chk("midrst pt_out", pt_out, '0);
    chk("midrst key_idx", 128'(key_idx), 128'(10));
    rst_n = 1;
    p = rnd128();
    run_block("after rst", encrypt(p), p, 0);

    // reset on the same edge as in_valid
    rst_n = 0;
    in_valid = 1;
    ct_in = rnd128();
    @(negedge clk);
    chk("rst+valid", 128'({busy, in_ready}), 128'(2'b01));
    in_valid = 0;
    rst_n = 1;
    @(negedge clk);
    chk("rst+valid idle", 128'({busy, in_ready, out_valid}), 128'(3'b010));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
